// File: rtl/text_console_pkg.sv
// Shared constants and state encoding for the text-mode VRAM writer.
package text_console_pkg;

   localparam int COLS           = 80;
   localparam int ROWS           = 30;
   localparam int WORDS_PER_ROW  = 20;
   localparam int VRAM_WORDS     = 600;
   localparam int COLOR_REG_ADDR = 600;

   localparam logic [6:0] CH_LF = 7'h0A;
   localparam logic [6:0] CH_CR = 7'h0D;
   localparam logic [6:0] CH_BS = 7'h08;

   typedef enum logic [2:0] {
      IDLE,
      PUT,
      SCROLL_RD,
      SCROLL_WR,
      SCROLL_FILL,
      CLEAR
   } state_t;

endpackage

// File: rtl/text_console_writer.sv
// Glyph stream to text VRAM writer with cursor, wrap, scroll and clear.
// Latency: write in the cycle after acceptance; scroll 1180 and clear 600 extra cycles.
// Backpressure: char_ready only in IDLE with no clear pending or arriving.
module text_console_writer #(
   parameter int COLS  = 80,
   parameter int ROWS  = 30,
   parameter int WORDS = COLS*ROWS/4
)(
   input  logic        axi_aclk,
   input  logic        axi_aresetn,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   output logic        char_ready,
   input  logic        clear_req,
   output logic [9:0]  vram_addr,
   output logic        vram_we,
   output logic [3:0]  vram_be,
   output logic [31:0] vram_wdata,
   input  logic [31:0] vram_rdata,
   output logic [6:0]  cursor_col,
   output logic [4:0]  cursor_row,
   output logic        busy
);
   import text_console_pkg::*;

   localparam logic [9:0] ROW_WORDS = 10'(COLS/4);
   localparam logic [9:0] LAST_WORD = 10'(WORDS-1);
   localparam logic [9:0] LAST_COPY = 10'(WORDS-COLS/4-1);
   localparam logic [6:0] LAST_COL  = 7'(COLS-1);
   localparam logic [4:0] LAST_ROW  = 5'(ROWS-1);

   state_t      state;
   logic        pend;
   logic [6:0]  code;
   logic [9:0]  w;
   logic [31:0] wdata_q;
   logic [11:0] idx;
   logic        clr;
   logic        in_print;
   logic        code_print;
   logic        nl;
   logic [6:0]  col_nx;

   assign clr        = pend || clear_req;
   assign char_ready = axi_aresetn && (state == IDLE) && !clr;
   assign busy       = (state != IDLE);
   assign idx        = ({7'd0, cursor_row} << 6) + ({7'd0, cursor_row} << 4) + {5'd0, cursor_col};
   assign in_print   = (char_data[6:0] >= 7'h20) && (char_data[6:0] <= 7'h7E);
   assign code_print = (code >= 7'h20) && (code <= 7'h7E);
   // Copy data is only valid one cycle after the read address, so it bypasses the register
   assign vram_wdata = (state == SCROLL_WR) ? vram_rdata : wdata_q;

   always_comb begin
      col_nx = cursor_col;
      nl     = 1'b0;
      if (code_print) begin
         if (cursor_col == LAST_COL) begin
            col_nx = 7'd0;
            nl     = 1'b1;
         end else begin
            col_nx = cursor_col + 7'd1;
         end
      end else if (code == CH_LF) begin
         col_nx = 7'd0;
         nl     = 1'b1;
      end else if (code == CH_CR) begin
         col_nx = 7'd0;
      end else if (code == CH_BS) begin
         col_nx = (cursor_col == 7'd0) ? 7'd0 : cursor_col - 7'd1;
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state      <= IDLE;
         pend       <= 1'b0;
         code       <= 7'd0;
         w          <= 10'd0;
         wdata_q    <= 32'd0;
         vram_addr  <= 10'd0;
         vram_we    <= 1'b0;
         vram_be    <= 4'd0;
         cursor_col <= 7'd0;
         cursor_row <= 5'd0;
      end else begin
         if (clear_req && state != IDLE) pend <= 1'b1;
         case (state)
            IDLE: begin
               if (clr) begin
                  state     <= CLEAR;
                  pend      <= 1'b0;
                  vram_addr <= 10'd0;
                  vram_we   <= 1'b1;
                  vram_be   <= 4'hF;
                  wdata_q   <= 32'd0;
               end else if (char_valid) begin
                  code  <= char_data[6:0];
                  state <= PUT;
                  if (in_print) begin
                     vram_addr <= idx[11:2];
                     vram_be   <= 4'b0001 << idx[1:0];
                     wdata_q   <= {4{char_data}};
                     vram_we   <= 1'b1;
                  end
               end
            end
            PUT: begin
               vram_we    <= 1'b0;
               cursor_col <= col_nx;
               if (nl && cursor_row != LAST_ROW) cursor_row <= cursor_row + 5'd1;
               if (nl && cursor_row == LAST_ROW) begin
                  state     <= SCROLL_RD;
                  w         <= 10'd0;
                  vram_addr <= ROW_WORDS;
               end else if (clr) begin
                  state     <= CLEAR;
                  pend      <= 1'b0;
                  vram_addr <= 10'd0;
                  vram_we   <= 1'b1;
                  vram_be   <= 4'hF;
                  wdata_q   <= 32'd0;
               end else begin
                  state <= IDLE;
               end
            end
            SCROLL_RD: begin
               vram_addr <= w;
               vram_we   <= 1'b1;
               vram_be   <= 4'hF;
               state     <= SCROLL_WR;
            end
            SCROLL_WR: begin
               if (w == LAST_COPY) begin
                  state     <= SCROLL_FILL;
                  vram_addr <= LAST_COPY + 10'd1;
                  wdata_q   <= 32'd0;
               end else begin
                  w         <= w + 10'd1;
                  vram_addr <= w + ROW_WORDS + 10'd1;
                  vram_we   <= 1'b0;
                  state     <= SCROLL_RD;
               end
            end
            SCROLL_FILL: begin
               if (vram_addr == LAST_WORD) begin
                  if (clr) begin
                     state     <= CLEAR;
                     pend      <= 1'b0;
                     vram_addr <= 10'd0;
                  end else begin
                     state   <= IDLE;
                     vram_we <= 1'b0;
                  end
               end else begin
                  vram_addr <= vram_addr + 10'd1;
               end
            end
            CLEAR: begin
               if (vram_addr == LAST_WORD) begin
                  state      <= IDLE;
                  vram_we    <= 1'b0;
                  cursor_col <= 7'd0;
                  cursor_row <= 5'd0;
               end else begin
                  vram_addr <= vram_addr + 10'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Streaming character writer for the text-mode VRAM of the HDMI text controller. It accepts one glyph byte at a time over a valid/ready handshake and writes it into the 80x30 glyph VRAM at a hardware cursor. It handles CR, LF, backspace, auto-wrap, full-screen scroll and screen clear. It is the write-side counterpart of the colour mapper, which reads the same 601-word VRAM layout: 4 glyphs per 32-bit word, glyph n at byte n[1:0], word 600 is the colour register.

## Interface
- COLS, default 80: glyph columns.
- ROWS, default 30: glyph rows.
- WORDS, default COLS*ROWS/4 = 600: glyph words; word index WORDS is the colour register and is never written.
- axi_aclk  in  1  sole clock, rising edge.
- axi_aresetn  in  1  reset, asynchronous, active-low.
- char_valid  in  1  glyph byte offered.
- char_data  in  8  bit7 = inverse flag, bits[6:0] = code.
- char_ready  out  1  block accepts char_data this cycle.
- clear_req  in  1  single-cycle pulse: blank the screen and home the cursor.
- vram_addr  out  10  word address 0..599.
- vram_we  out  1  write strobe.
- vram_be  out  4  byte enables; bit k selects glyph byte k.
- vram_wdata  out  32  write data.
- vram_rdata  in  32  read data, valid exactly 1 cycle after vram_addr is presented with vram_we=0.
- cursor_col  out  7  current column, 0..79.
- cursor_row  out  5  current row, 0..29.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, PUT, SCROLL_RD, SCROLL_WR, SCROLL_FILL, CLEAR.
- IDLE:
  - char_ready = 1 when no clear is pending.
  - A pending clear moves to CLEAR.
  - char_valid && char_ready latches char_data and moves to PUT.
- PUT, exactly one cycle, selected by code = char_data[6:0]:
  - 0x20..0x7E printable: glyph index i = row*80+col. Drive vram_addr = i>>2, vram_be = 1<<i[1:0], vram_wdata = byte replicated ×4, vram_we = 1. Then col+1. At 80, col resets to 0 and a newline occurs.
  - 0x0A LF: col=0, newline.
  - 0x0D CR: col=0.
  - 0x08 BS: col-1, saturating at 0. No erase.
  - Any other code: consumed, no write, cursor unchanged.
  - Newline: if row<29, row+1 and return to IDLE. If row==29, go to SCROLL_RD with word pointer w=0, and row stays 29.
- Scroll, covering w = 0..579:
  - SCROLL_RD presents address w+20 with vram_we=0.
  - SCROLL_WR writes vram_rdata to address w with be=4'hF.
  - This alternates until w=579 is written, then moves to SCROLL_FILL.
- SCROLL_FILL: writes 32'h0 with be=4'hF to words 580..599, one per cycle, then returns to IDLE.
- CLEAR: writes 32'h0 with be=4'hF to words 0..599, one per cycle. Then sets cursor to (0,0) and returns to IDLE.
- clear_req arriving in any non-IDLE state sets a pending flag. The current operation finishes first, then CLEAR runs.
- clear_req in IDLE in the same cycle as char_valid: clear wins and the character is not accepted, because char_ready is forced to 0 that cycle.
- vram_addr never exceeds 599.

## Timing
- Reset: state=IDLE, cursor (0,0), pending clear=0, vram_we=0, vram_be=0, vram_addr=0, vram_wdata=0, busy=0.
- char_ready is 0 while axi_aresetn is low and is 1 in the first cycle after deassertion.
- Handshake accepted at cycle N → PUT and its VRAM write at N+1 → char_ready high again at N+2. Throughput is one character per 2 cycles.
- Cursor outputs are registered and update at the end of PUT.
- Scroll: 1160 cycles of copy plus 20 cycles of fill after PUT, so 1182 cycles from acceptance to char_ready.
- Clear: 600 cycles after entering CLEAR.
- Reset asserted mid-operation aborts immediately with no further writes. VRAM contents are then undefined.
- char_data may change freely once accepted.

## Structure
- Package text_console_pkg holds:
  - COLS, ROWS, WORDS_PER_ROW=20, VRAM_WORDS=600, COLOR_REG_ADDR=600.
  - Control-code constants CH_LF, CH_CR, CH_BS.
  - The state enum typedef.
- One module; no sub-module is natural. Index arithmetic is inline: row*80 as (row<<6)+(row<<4).

## Test plan
- After reset, send 0x41 → single write: addr 0, be 4'b0001, wdata 32'h41414141. Cursor then reads (1,0).
- Send 0xC1 at cursor (3,2) → index 163: addr 40, be 4'b1000, byte 0xC1. Cursor then reads (4,2).
- Fill row 29 to col 79 with 0x58, then send one more 0x58 → write to addr 599 byte 3. A full scroll follows: word 0 gets the old word 20, words 580..599 become 0. Cursor ends at (0,29); busy lasts 1180 cycles after PUT.
- Send CR, LF, BS at col 0, and 0x7F → no VRAM writes for any. Cursor moves per the rules; BS at col 0 stays at 0.
- Pulse clear_req mid-scroll → scroll completes, then 600 zero writes, cursor (0,0). Word 600 is never addressed.
- Assert axi_aresetn low during CLEAR → vram_we drops asynchronously, cursor reads (0,0), char_ready is 1 on the first cycle after release.
